// File: rtl/dram_test_sequencer.sv
// -----------------------------------------------------------------------------
// dram_test_sequencer
// Write-then-read-back memory test pass. NUM_OPS address-tagged pattern
// words are written, then read back from the same address sequence. Each
// returned word is checked against the pattern for the address at the head
// of an in-order outstanding-read FIFO.
//
// Ports
//   clk               rising-edge clock
//   i_rst             asynchronous active-high reset
//   i_start           start-pass pulse, only honoured in IDLE or DONE
//   i_waddr/i_raddr   current write/read address from the address generator
//   o_wen/o_ren       advance pulses to the generator, one per handshake
//   o_cmd_*           command channel (valid/ready, we, addr, wdata)
//   i_rdata_valid/i_rdata  in-order read returns
//   o_busy/o_done/o_pass   pass status
//   o_err_count       saturating miscompare count for the current pass
//   o_first_err_addr  address of the first error in the current pass
// -----------------------------------------------------------------------------
module dram_test_sequencer #(
    parameter int ADDR_WIDTH = 27,
    parameter int DATA_WIDTH = 128,
    parameter int NUM_OPS    = 1024,
    parameter int RD_DEPTH   = 16
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic                  o_wen,
    output logic                  o_ren,
    output logic                  o_cmd_valid,
    input  logic                  i_cmd_ready,
    output logic                  o_cmd_we,
    output logic [ADDR_WIDTH-1:0] o_cmd_addr,
    output logic [DATA_WIDTH-1:0] o_cmd_wdata,
    input  logic                  i_rdata_valid,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_pass,
    output logic [15:0]           o_err_count,
    output logic [ADDR_WIDTH-1:0] o_first_err_addr
);

    localparam int PTR_W = $clog2(RD_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int LANES = DATA_WIDTH / 32;
    localparam logic [15:0]      LAST_OP   = 16'(NUM_OPS - 1);
    localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(RD_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Each 32-bit lane carries its lane index in the top nibble and the
    // zero-extended address below, so lane swaps and address aliasing both
    // show up as miscompares.
    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a);
        logic [DATA_WIDTH-1:0] p;
        logic [27:0]           a28;
        p   = '0;
        a28 = 28'(a);
        for (int k = 0; k < LANES; k++) begin
            p[32*k +: 32] = {4'(k), a28};
        end
        return p;
    endfunction

    state_t                state_q, state_d;
    logic [15:0]           wr_cnt_q, rd_cnt_q;
    logic [15:0]           err_cnt_q;
    logic [ADDR_WIDTH-1:0] first_err_q;
    logic [ADDR_WIDTH-1:0] fifo_mem_q [RD_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      fifo_cnt_q;

    logic                  fifo_full_s, fifo_empty_s;
    logic                  wr_hs_s, rd_hs_s, pop_s, start_s, err_evt_s;
    logic [ADDR_WIDTH-1:0] head_s, err_addr_s;

    assign fifo_full_s  = (fifo_cnt_q == FIFO_FULL);
    assign fifo_empty_s = (fifo_cnt_q == {CNT_W{1'b0}});
    assign head_s       = fifo_mem_q[rd_ptr_q];

    // Handshakes: reads are only offered while the FIFO has room.
    assign wr_hs_s = (state_q == ST_WRITE) & i_cmd_ready;
    assign rd_hs_s = (state_q == ST_READ) & ~fifo_full_s & i_cmd_ready;
    assign o_wen   = wr_hs_s;
    assign o_ren   = rd_hs_s;

    // A return with nothing outstanding is itself an error (address 0).
    assign pop_s      = i_rdata_valid & ~fifo_empty_s;
    assign err_evt_s  = i_rdata_valid & (fifo_empty_s | (i_rdata != pattern(head_s)));
    assign err_addr_s = fifo_empty_s ? {ADDR_WIDTH{1'b0}} : head_s;

    assign o_err_count      = err_cnt_q;
    assign o_first_err_addr = first_err_q;
    assign o_pass           = o_done & (err_cnt_q == 16'h0000);

    // State register.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and command/status decode.
    always_comb begin
        state_d     = state_q;
        start_s     = 1'b0;
        o_cmd_valid = 1'b0;
        o_cmd_we    = 1'b0;
        o_cmd_addr  = {ADDR_WIDTH{1'b0}};
        o_cmd_wdata = {DATA_WIDTH{1'b0}};
        o_busy      = 1'b0;
        o_done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_WRITE;
                    start_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                o_cmd_valid = 1'b1;
                o_cmd_we    = 1'b1;
                o_cmd_addr  = i_waddr;
                o_cmd_wdata = pattern(i_waddr);
                o_busy      = 1'b1;
                if (wr_hs_s && (wr_cnt_q == LAST_OP)) begin
                    state_d = ST_READ;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_READ: begin
                o_cmd_valid = ~fifo_full_s;
                o_cmd_addr  = i_raddr;
                o_busy      = 1'b1;
                if (rd_hs_s && (rd_cnt_q == LAST_OP)) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_DRAIN: begin
                o_busy = 1'b1;
                if (fifo_empty_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                o_done = 1'b1;
                if (i_start) begin
                    state_d = ST_WRITE;
                    start_s = 1'b1;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Operation counters and error bookkeeping; a start clears the pass.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            wr_cnt_q    <= 16'h0000;
            rd_cnt_q    <= 16'h0000;
            err_cnt_q   <= 16'h0000;
            first_err_q <= {ADDR_WIDTH{1'b0}};
        end else if (start_s) begin
            wr_cnt_q    <= 16'h0000;
            rd_cnt_q    <= 16'h0000;
            err_cnt_q   <= 16'h0000;
            first_err_q <= {ADDR_WIDTH{1'b0}};
        end else begin
            if (wr_hs_s) begin
                wr_cnt_q <= wr_cnt_q + 16'h0001;
            end
            if (rd_hs_s) begin
                rd_cnt_q <= rd_cnt_q + 16'h0001;
            end
            if (err_evt_s) begin
                if (err_cnt_q != 16'hFFFF) begin
                    err_cnt_q <= err_cnt_q + 16'h0001;
                end
                // The count never returns to zero within a pass, so zero
                // identifies the first error.
                if (err_cnt_q == 16'h0000) begin
                    first_err_q <= err_addr_s;
                end
            end
        end
    end

    // Outstanding-read FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            fifo_cnt_q <= {CNT_W{1'b0}};
        end else begin
            if (rd_hs_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({rd_hs_s, pop_s})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_ONE;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_ONE;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    // FIFO storage; contents are only meaningful under the pointers.
    always_ff @(posedge clk) begin
        if (rd_hs_s) begin
            fifo_mem_q[wr_ptr_q] <= i_raddr;
        end
    end

endmodule

// File: tb/tb_dram_test_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dram_test_sequencer
// Directed bench: an address-generator model (start 8'h10, step 8'h03) and
// a memory model with configurable read latency drive the sequencer. Inputs
// change on the falling edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_dram_test_sequencer;

    localparam int AW    = 8;
    localparam int DW    = 64;
    localparam int NOPS  = 4;
    localparam int DEPTH = 2;

    logic          clk;
    logic          i_rst, i_start;
    logic [AW-1:0] i_waddr, i_raddr;
    logic          o_wen, o_ren, o_cmd_valid, i_cmd_ready, o_cmd_we;
    logic [AW-1:0] o_cmd_addr;
    logic [DW-1:0] o_cmd_wdata;
    logic          i_rdata_valid;
    logic [DW-1:0] i_rdata;
    logic          o_busy, o_done, o_pass;
    logic [15:0]   o_err_count;
    logic [AW-1:0] o_first_err_addr;

    dram_test_sequencer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_OPS(NOPS), .RD_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .i_rst(i_rst), .i_start(i_start),
        .i_waddr(i_waddr), .i_raddr(i_raddr),
        .o_wen(o_wen), .o_ren(o_ren),
        .o_cmd_valid(o_cmd_valid), .i_cmd_ready(i_cmd_ready), .o_cmd_we(o_cmd_we),
        .o_cmd_addr(o_cmd_addr), .o_cmd_wdata(o_cmd_wdata),
        .i_rdata_valid(i_rdata_valid), .i_rdata(i_rdata),
        .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass),
        .o_err_count(o_err_count), .o_first_err_addr(o_first_err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vec_cnt = 0;
    int miscmp_cnt = 0;

    // Environment state
    logic [AW-1:0] gen_w, gen_r;
    bit            adv_w, adv_r;
    bit            rst_req, start_req, ready_toggle;
    int            lat, flip_idx, ret_idx, cyc, occ, max_occ;
    int            wen_cnt, ren_cnt, hs_viol, full_viol, stab_viol, stall_cnt;
    bit            stall_prev, first_wseen, done_seen;
    logic [AW-1:0] prev_addr, first_waddr;
    logic [DW-1:0] prev_wdata, first_wdata;
    logic          prev_we;
    logic [DW-1:0] mem [256];
    int            rq_due [$];
    logic [DW-1:0] rq_data [$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscmp_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs on the falling edge, observe 1 ns later.
    task automatic step();
        bit popped;
        popped = 1'b0;
        @(negedge clk);
        cyc++;
        i_rst   = rst_req;
        i_start = start_req;
        if (rst_req) begin
            gen_w = 8'h10; gen_r = 8'h10; adv_w = 1'b0; adv_r = 1'b0;
            occ = 0; stall_prev = 1'b0;
        end else begin
            if (adv_w) gen_w = gen_w + 8'h03;
            if (adv_r) gen_r = gen_r + 8'h03;
            adv_w = 1'b0; adv_r = 1'b0;
        end
        i_waddr     = gen_w;
        i_raddr     = gen_r;
        i_cmd_ready = ready_toggle ? ~i_cmd_ready : 1'b1;
        i_rdata_valid = 1'b0;
        i_rdata       = '0;
        if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
            i_rdata_valid = 1'b1;
            i_rdata       = rq_data[0];
            ret_idx++;
            if (ret_idx == flip_idx) i_rdata[0] = ~i_rdata[0];
            void'(rq_due.pop_front());
            void'(rq_data.pop_front());
            popped = 1'b1;
        end
        #1;
        if ((o_wen !== (o_cmd_valid & i_cmd_ready & o_cmd_we)) ||
            (o_ren !== (o_cmd_valid & i_cmd_ready & ~o_cmd_we)) || (o_wen & o_ren))
            hs_viol++;
        if (o_cmd_valid && !o_cmd_we && occ >= DEPTH) full_viol++;
        if (stall_prev && (!o_cmd_valid || o_cmd_addr !== prev_addr ||
                           o_cmd_wdata !== prev_wdata || o_cmd_we !== prev_we))
            stab_viol++;
        stall_prev = o_cmd_valid && !i_cmd_ready;
        if (stall_prev) stall_cnt++;
        prev_addr = o_cmd_addr; prev_wdata = o_cmd_wdata; prev_we = o_cmd_we;
        if (o_wen) begin
            wen_cnt++;
            mem[o_cmd_addr] = o_cmd_wdata;
            adv_w = 1'b1;
            if (!first_wseen) begin
                first_wseen = 1'b1; first_waddr = o_cmd_addr; first_wdata = o_cmd_wdata;
            end
        end
        if (o_ren) begin
            ren_cnt++;
            rq_due.push_back(cyc + lat);
            rq_data.push_back(mem[o_cmd_addr]);
            adv_r = 1'b1;
            occ++;
        end
        if (popped && occ > 0) occ--;
        if (occ > max_occ) max_occ = occ;
    endtask

    task automatic clear_stats(input bit tog, input int l, input int flip);
        ready_toggle = tog; lat = l; flip_idx = flip; ret_idx = 0;
        wen_cnt = 0; ren_cnt = 0; hs_viol = 0; full_viol = 0; stab_viol = 0;
        stall_cnt = 0; max_occ = 0; first_wseen = 1'b0;
    endtask

    task automatic run_pass(input bit tog, input int l, input int flip);
        clear_stats(tog, l, flip);
        start_req = 1'b1;
        step();
        start_req = 1'b0;
        done_seen = 1'b0;
        for (int n = 0; n < 300 && !done_seen; n++) begin
            step();
            if (o_done) done_seen = 1'b1;
        end
        check_eq("pass_done_timeout", 64'(done_seen), 64'd1);
        check_eq("wen_count", 64'(wen_cnt), 64'd4);
        check_eq("ren_count", 64'(ren_cnt), 64'd4);
        check_eq("handshake_pulses", 64'(hs_viol), 64'd0);
        check_eq("valid_while_full", 64'(full_viol), 64'd0);
    endtask

    task automatic check_idle_zero(input string tag);
        check_eq({tag, "_valid"}, 64'(o_cmd_valid), 64'd0);
        check_eq({tag, "_wen_ren"}, 64'({o_wen, o_ren}), 64'd0);
        check_eq({tag, "_busy_done_pass"}, 64'({o_busy, o_done, o_pass}), 64'd0);
        check_eq({tag, "_cmd_addr"}, 64'(o_cmd_addr), 64'd0);
        check_eq({tag, "_cmd_wdata"}, 64'(o_cmd_wdata), 64'd0);
    endtask

    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_cmd_ready = 1'b1;
        i_rdata_valid = 1'b0; i_rdata = '0; i_waddr = '0; i_raddr = '0;
        gen_w = 8'h10; gen_r = 8'h10; adv_w = 1'b0; adv_r = 1'b0;
        rst_req = 1'b1; start_req = 1'b0; cyc = 0; occ = 0; stall_prev = 1'b0;
        clear_stats(1'b0, 3, 0);

        // Reset state
        step(); step();
        check_idle_zero("reset");
        check_eq("reset_err_count", 64'(o_err_count), 64'd0);
        check_eq("reset_first_err", 64'(o_first_err_addr), 64'd0);
        rst_req = 1'b0;
        step();
        check_idle_zero("idle");

        // Clean pass, always ready, latency 3
        run_pass(1'b0, 3, 0);
        check_eq("p1_first_waddr", 64'(first_waddr), 64'h10);
        check_eq("p1_first_wdata", first_wdata, 64'h1000_0010_0000_0010);
        check_eq("p1_pass", 64'(o_pass), 64'd1);
        check_eq("p1_err_count", 64'(o_err_count), 64'd0);

        // Ready toggling: command held while stalled
        run_pass(1'b1, 3, 0);
        check_eq("p2_stable_stall", 64'(stab_viol), 64'd0);
        check_eq("p2_stalls_seen", 64'(stall_cnt > 0), 64'd1);
        check_eq("p2_pass", 64'(o_pass), 64'd1);

        // Long latency fills the 2-deep outstanding FIFO
        run_pass(1'b0, 10, 0);
        check_eq("p3_max_outstanding", 64'(max_occ), 64'd2);
        check_eq("p3_pass", 64'(o_pass), 64'd1);

        // Bit 0 flipped on 2nd return; pass writes 34,37,3A,3D
        run_pass(1'b0, 3, 2);
        check_eq("p4_err_count", 64'(o_err_count), 64'd1);
        check_eq("p4_first_err", 64'(o_first_err_addr), 64'h37);
        check_eq("p4_pass", 64'(o_pass), 64'd0);
        check_eq("p4_done", 64'(o_done), 64'd1);

        // Stray return in IDLE counts, then start clears it
        rst_req = 1'b1; step(); rst_req = 1'b0; step();
        rq_due.push_back(cyc + 1);
        rq_data.push_back(64'h0000_DEAD_0000_BEEF);
        step(); step();
        check_eq("stray_err_count", 64'(o_err_count), 64'd1);
        check_eq("stray_first_err", 64'(o_first_err_addr), 64'd0);
        check_eq("stray_busy_done", 64'({o_busy, o_done}), 64'd0);
        run_pass(1'b0, 3, 0);
        check_eq("p5_err_cleared", 64'(o_err_count), 64'd0);
        check_eq("p5_pass", 64'(o_pass), 64'd1);

        // Reset while two reads are outstanding
        clear_stats(1'b0, 10, 0);
        start_req = 1'b1; step(); start_req = 1'b0;
        for (int n = 0; n < 100 && ren_cnt < 2; n++) step();
        check_eq("p6_reads_issued", 64'(ren_cnt), 64'd2);
        rst_req = 1'b1;
        step();
        check_idle_zero("midreset");
        rst_req = 1'b0;
        for (int n = 0; n < 14; n++) step();
        check_eq("p6_stale_errors", 64'(o_err_count), 64'd2);
        check_eq("p6_stale_first_err", 64'(o_first_err_addr), 64'd0);
        check_eq("p6_queue_drained", 64'(rq_due.size()), 64'd0);
        run_pass(1'b0, 3, 0);
        check_eq("p7_pass", 64'(o_pass), 64'd1);
        check_eq("p7_err_count", 64'(o_err_count), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end

endmodule
